// File: rtl/keccak_xif_mctx_ctrl.sv
// XIF coprocessor controller for multi-context Keccak state access and permutation sequencing.
// Optional STATUS op enabled by defining KECCAK_XIF_STATUS_EN.
module keccak_xif_mctx_ctrl #(
  parameter int unsigned NUM_CTX    = 2,
  parameter int unsigned PEND_DEPTH = 4,
  parameter int unsigned RES_DEPTH  = 2,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned CTX_W      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  output logic               issue_accept_o,
  input  logic [ID_W-1:0]    issue_id_i,
  input  logic [1:0]         issue_op_i,
  input  logic [CTX_W-1:0]   issue_ctx_i,
  input  logic [5:0]         issue_idx_i,
  input  logic [31:0]        issue_rs1_i,
  input  logic               commit_valid_i,
  input  logic [ID_W-1:0]    commit_id_i,
  input  logic               commit_kill_i,
  output logic               st_we_o,
  output logic               st_re_o,
  output logic [CTX_W-1:0]   st_ctx_o,
  output logic [5:0]         st_idx_o,
  output logic [31:0]        st_wdata_o,
  input  logic [31:0]        st_rdata_i,
  output logic               perm_start_o,
  output logic [CTX_W-1:0]   perm_ctx_o,
  input  logic               perm_done_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [ID_W-1:0]    result_id_o,
  output logic [31:0]        result_data_o,
  output logic [NUM_CTX-1:0] busy_o,
  output logic               err_o
);

`ifdef KECCAK_XIF_STATUS_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  localparam int unsigned PAW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int unsigned RAW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  localparam logic [1:0] OpLoad   = 2'b00;
  localparam logic [1:0] OpStart  = 2'b01;
  localparam logic [1:0] OpRead   = 2'b10;
  localparam logic [1:0] OpStatus = 2'b11;

  typedef enum logic [1:0] {ExIdle, ExRead, ExResp} ex_state_e;

  // Pointers carry one extra bit and wrap at twice the depth so full and empty differ.
  function automatic logic [PAW-1:0] pidx(input logic [PAW:0] p);
    return p[PAW-1:0];
  endfunction

  function automatic logic [PAW:0] pinc(input logic [PAW:0] p);
    return (32'(p) == 2 * PEND_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RAW-1:0] ridx(input logic [RAW:0] p);
    return (RES_DEPTH > 1) ? p[RAW-1:0] : '0;
  endfunction

  function automatic logic [RAW:0] rinc(input logic [RAW:0] p);
    return (32'(p) == 2 * RES_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  logic [PAW:0]       pwr_q, pwr_d, prd_q, prd_d, pcm_q, pcm_d;
  logic [ID_W-1:0]    pend_id_q   [PEND_DEPTH];
  logic [ID_W-1:0]    pend_id_d   [PEND_DEPTH];
  logic [1:0]         pend_op_q   [PEND_DEPTH];
  logic [1:0]         pend_op_d   [PEND_DEPTH];
  logic [CTX_W-1:0]   pend_ctx_q  [PEND_DEPTH];
  logic [CTX_W-1:0]   pend_ctx_d  [PEND_DEPTH];
  logic [5:0]         pend_idx_q  [PEND_DEPTH];
  logic [5:0]         pend_idx_d  [PEND_DEPTH];
  logic [31:0]        pend_rs1_q  [PEND_DEPTH];
  logic [31:0]        pend_rs1_d  [PEND_DEPTH];
  logic               pend_kill_q [PEND_DEPTH];
  logic               pend_kill_d [PEND_DEPTH];

  logic [RAW:0]       rwr_q, rwr_d, rrd_q, rrd_d;
  logic [ID_W-1:0]    res_id_q   [RES_DEPTH];
  logic [ID_W-1:0]    res_id_d   [RES_DEPTH];
  logic [31:0]        res_data_q [RES_DEPTH];
  logic [31:0]        res_data_d [RES_DEPTH];

  ex_state_e          ex_q, ex_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_CTX-1:0] busy_q, busy_d;
  logic               err_q, err_d;

  logic               pend_full, op_ok, hs, cm_hit, head_rdy, pop_head;
  logic               res_full, res_empty, push_en;
  logic [31:0]        push_data;
  logic               st_we, st_re, perm_start;
  logic [PAW-1:0]     hi;
  logic [1:0]         head_op;
  logic [CTX_W-1:0]   head_ctx;
  logic [5:0]         head_idx;
  logic [31:0]        head_rs1;
  logic [ID_W-1:0]    head_id;
  logic               head_kill;

  assign pend_full = (pidx(pwr_q) == pidx(prd_q)) && (pwr_q != prd_q);
  assign res_full  = (ridx(rwr_q) == ridx(rrd_q)) && (rwr_q != rrd_q);
  assign res_empty = (rwr_q == rrd_q);

  always_comb begin
    op_ok = 1'b1;
    unique case (issue_op_i)
      OpLoad, OpRead: op_ok = (issue_idx_i < 6'd50);
      OpStart:        op_ok = 1'b1;
      OpStatus:       op_ok = StatusEn;
      default:        op_ok = 1'b0;
    endcase
  end

  assign hs             = issue_valid_i && !pend_full;
  assign issue_ready_o  = !pend_full;
  assign issue_accept_o = hs && op_ok && (32'(issue_ctx_i) < NUM_CTX);

  assign hi        = pidx(prd_q);
  assign head_rdy  = (prd_q != pcm_q);
  assign head_op   = pend_op_q[hi];
  assign head_ctx  = pend_ctx_q[hi];
  assign head_idx  = pend_idx_q[hi];
  assign head_rs1  = pend_rs1_q[hi];
  assign head_id   = pend_id_q[hi];
  assign head_kill = pend_kill_q[hi];

  // Only the registered write pointer is visible, so an entry issued this cycle cannot match.
  assign cm_hit = commit_valid_i && (pcm_q != pwr_q) && (commit_id_i == pend_id_q[pidx(pcm_q)]);

  always_comb begin
    pwr_d       = pwr_q;
    prd_d       = prd_q;
    pcm_d       = pcm_q;
    pend_id_d   = pend_id_q;
    pend_op_d   = pend_op_q;
    pend_ctx_d  = pend_ctx_q;
    pend_idx_d  = pend_idx_q;
    pend_rs1_d  = pend_rs1_q;
    pend_kill_d = pend_kill_q;
    rwr_d       = rwr_q;
    rrd_d       = rrd_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    ex_d        = ex_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    err_d       = err_q;
    st_we       = 1'b0;
    st_re       = 1'b0;
    perm_start  = 1'b0;
    push_en     = 1'b0;
    push_data   = '0;
    pop_head    = 1'b0;

    if (issue_accept_o) begin
      pend_id_d[pidx(pwr_q)]   = issue_id_i;
      pend_op_d[pidx(pwr_q)]   = issue_op_i;
      pend_ctx_d[pidx(pwr_q)]  = issue_ctx_i;
      pend_idx_d[pidx(pwr_q)]  = issue_idx_i;
      pend_rs1_d[pidx(pwr_q)]  = issue_rs1_i;
      pend_kill_d[pidx(pwr_q)] = 1'b0;
      pwr_d = pinc(pwr_q);
    end

    if (cm_hit) begin
      pend_kill_d[pidx(pcm_q)] = commit_kill_i;
      pcm_d = pinc(pcm_q);
    end else if (commit_valid_i) begin
      err_d = 1'b1;
    end

    // Single permutation engine: done clears whichever context is active.
    if (perm_done_i) begin
      if (|busy_q) busy_d = '0;
      else         err_d  = 1'b1;
    end

    unique case (ex_q)
      ExIdle: begin
        if (head_rdy) begin
          if (head_kill) begin
            pop_head = 1'b1;
          end else begin
            unique case (head_op)
              OpLoad: begin
                if (!busy_q[head_ctx] && !res_full) begin
                  st_we    = 1'b1;
                  push_en  = 1'b1;
                  pop_head = 1'b1;
                end
              end
              OpStart: begin
                if ((busy_q == '0) && !res_full) begin
                  perm_start       = 1'b1;
                  busy_d[head_ctx] = 1'b1;
                  push_en          = 1'b1;
                  pop_head         = 1'b1;
                end
              end
              OpRead: begin
                if (!busy_q[head_ctx]) begin
                  st_re = 1'b1;
                  ex_d  = ExRead;
                end
              end
              default: begin
                if (!res_full) begin
                  push_data = 32'(busy_q);
                  push_en   = 1'b1;
                  pop_head  = 1'b1;
                end
              end
            endcase
          end
        end
      end
      ExRead: begin
        rdata_d = st_rdata_i;
        ex_d    = ExResp;
      end
      ExResp: begin
        if (!res_full) begin
          push_data = rdata_q;
          push_en   = 1'b1;
          pop_head  = 1'b1;
          ex_d      = ExIdle;
        end
      end
      default: ex_d = ExIdle;
    endcase

    if (pop_head) prd_d = pinc(prd_q);

    // Push is gated by registered fullness, so a pop in the same cycle does not make room.
    if (push_en) begin
      res_id_d[ridx(rwr_q)]   = head_id;
      res_data_d[ridx(rwr_q)] = push_data;
      rwr_d = rinc(rwr_q);
    end
    if (!res_empty && result_ready_i) rrd_d = rinc(rrd_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwr_q   <= '0;
      prd_q   <= '0;
      pcm_q   <= '0;
      rwr_q   <= '0;
      rrd_q   <= '0;
      ex_q    <= ExIdle;
      rdata_q <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      pwr_q   <= pwr_d;
      prd_q   <= prd_d;
      pcm_q   <= pcm_d;
      rwr_q   <= rwr_d;
      rrd_q   <= rrd_d;
      ex_q    <= ex_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pend_id_q   <= pend_id_d;
    pend_op_q   <= pend_op_d;
    pend_ctx_q  <= pend_ctx_d;
    pend_idx_q  <= pend_idx_d;
    pend_rs1_q  <= pend_rs1_d;
    pend_kill_q <= pend_kill_d;
    res_id_q    <= res_id_d;
    res_data_q  <= res_data_d;
  end

  // Payload outputs are zeroed whenever their strobe or valid is low.
  assign st_we_o        = st_we;
  assign st_re_o        = st_re;
  assign st_ctx_o       = (st_we || st_re) ? head_ctx : '0;
  assign st_idx_o       = (st_we || st_re) ? head_idx : '0;
  assign st_wdata_o     = st_we ? head_rs1 : '0;
  assign perm_start_o   = perm_start;
  assign perm_ctx_o     = perm_start ? head_ctx : '0;
  assign result_valid_o = !res_empty;
  assign result_id_o    = res_empty ? '0 : res_id_q[ridx(rrd_q)];
  assign result_data_o  = res_empty ? '0 : res_data_q[ridx(rrd_q)];
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule
